// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: load/store initiator for the MEM stage.
// Drives a word-wide data memory (addr, write_data, wr_en, rd_en, read_data),
// takes one byte/half/word request at a time and returns extended load data.
// Sub-word stores are read-modify-write because the memory only has a
// whole-word write enable.
// Optional build macro: LSU_ACCESS_CNT_EN adds ld_count/st_count outputs.
//
// Handshake: a request is accepted on a rising edge where req_valid and
// req_ready are both 1; req_ready is 1 only in IDLE. resp_valid is a
// one-cycle pulse with no backpressure, and req_ready rises as it falls.
module lsu_mem_initiator #(
  parameter int MEM_RD_LAT = 1,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       write_data,
  output logic              wr_en,
  output logic              rd_en,
  output logic [1:0]        dbg_state,
`ifdef LSU_ACCESS_CNT_EN
  output logic [31:0]       ld_count,
  output logic [31:0]       st_count,
`endif
  input  logic [31:0]       read_data
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_WRITE   = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  // The counter holds the remaining rd_en cycles after the current one.
  localparam logic [1:0] CNT_INIT = 2'(MEM_RD_LAT - 1);

  state_t            r_state;
  logic              r_req_ready;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [1:0]        r_lane;
  logic [15:0]       r_wdata;
  logic [1:0]        r_cnt;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [31:0]       r_resp_rdata;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_write_data;
  logic              r_wr_en;
  logic              r_rd_en;

  logic              w_misaligned;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load_ext;
  logic [31:0]       w_merged;

  // Alignment check on the live request, used only on the accept edge.
  always_comb begin
    w_misaligned = 1'b0;
    case (req_size)
      2'd0:    w_misaligned = 1'b0;
      2'd1:    w_misaligned = req_addr[0];
      2'd2:    w_misaligned = |req_addr[1:0];
      default: w_misaligned = 1'b1;
    endcase
  end

  // Lane extraction with sign/zero extension, and lane merge for RMW stores.
  always_comb begin
    w_byte     = read_data[{r_lane, 3'b000} +: 8];
    w_half     = r_lane[1] ? read_data[31:16] : read_data[15:0];
    w_load_ext = read_data;
    w_merged   = read_data;
    case (r_size)
      2'd0: begin
        w_load_ext = {{24{~r_unsigned & w_byte[7]}}, w_byte};
        w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
      end
      2'd1: begin
        w_load_ext = {{16{~r_unsigned & w_half[15]}}, w_half};
        if (r_lane[1]) w_merged[31:16] = r_wdata;
        else           w_merged[15:0]  = r_wdata;
      end
      default: begin
        w_load_ext = read_data;
        w_merged   = read_data;
      end
    endcase
  end

  // Access FSM; every output is registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b1;
      r_we         <= 1'b0;
      r_size       <= 2'd0;
      r_unsigned   <= 1'b0;
      r_lane       <= 2'd0;
      r_wdata      <= 16'd0;
      r_cnt        <= 2'd0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_addr       <= '0;
      r_write_data <= 32'd0;
      r_wr_en      <= 1'b0;
      r_rd_en      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_req_ready <= 1'b0;
            r_we        <= req_we;
            r_size      <= req_size;
            r_unsigned  <= req_unsigned;
            r_lane      <= req_addr[1:0];
            r_wdata     <= req_wdata[15:0];
            if (w_misaligned) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'd0;
              r_state      <= S_RESP;
            end else if (req_we && (req_size == 2'd2)) begin
              r_addr       <= {req_addr[ADDR_W-1:2], 2'b00};
              r_write_data <= req_wdata;
              r_wr_en      <= 1'b1;
              r_state      <= S_WRITE;
            end else begin
              r_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              r_rd_en <= 1'b1;
              r_cnt   <= CNT_INIT;
              r_state <= S_RD_WAIT;
            end
          end
        end
        S_RD_WAIT: begin
          if (r_cnt != 2'd0) begin
            r_cnt <= r_cnt - 2'd1;
          end else begin
            r_rd_en <= 1'b0;
            if (r_we) begin
              r_write_data <= w_merged;
              r_wr_en      <= 1'b1;
              r_state      <= S_WRITE;
            end else begin
              r_resp_rdata <= w_load_ext;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b0;
              r_state      <= S_RESP;
            end
          end
        end
        S_WRITE: begin
          r_wr_en      <= 1'b0;
          r_resp_rdata <= 32'd0;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: begin
          r_rd_en      <= 1'b0;
          r_wr_en      <= 1'b0;
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

`ifdef LSU_ACCESS_CNT_EN
  logic [31:0] r_ld_count;
  logic [31:0] r_st_count;

  // Count successful accesses as their response completes; errors do not count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ld_count <= 32'd0;
      r_st_count <= 32'd0;
    end else if ((r_state == S_RESP) && !r_resp_err) begin
      if (r_we) r_st_count <= r_st_count + 32'd1;
      else      r_ld_count <= r_ld_count + 32'd1;
    end
  end

  assign ld_count = r_ld_count;
  assign st_count = r_st_count;
`endif

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign addr       = r_addr;
  assign write_data = r_write_data;
  assign wr_en      = r_wr_en;
  assign rd_en      = r_rd_en;
  assign dbg_state  = r_state;

endmodule
